// File: rtl/reg_file_rename_pkg.sv
// Shared sizing for the renaming register file.
package reg_file_rename_pkg;
  localparam int REG_NUM   = 32;
  localparam int REG_POS_W = 5;
  localparam int DATA_W    = 32;
  localparam int ROB_POS_W = 4;

  // A same-cycle commit to a live (non-x0) register that a reader may see.
  function automatic logic hits_commit(input logic rdy, input logic commit,
                                       input logic [REG_POS_W-1:0] commit_rd,
                                       input logic [REG_POS_W-1:0] pos);
    return rdy && commit && (commit_rd == pos) && (pos != '0);
  endfunction
endpackage

// File: rtl/reg_file_read_port.sv
// One source-operand lookup with commit bypass.
module reg_file_read_port
  import reg_file_rename_pkg::*;
(
  input  logic                                rdy,
  input  logic                                commit,
  input  logic [REG_POS_W-1:0]                commit_rd,
  input  logic [DATA_W-1:0]                   commit_val,
  input  logic [ROB_POS_W-1:0]                commit_rob_pos,
  input  logic [REG_POS_W-1:0]                pos,
  input  logic [REG_NUM-1:0][DATA_W-1:0]      vals,
  input  logic [REG_NUM-1:0]                  busys,
  input  logic [REG_NUM-1:0][ROB_POS_W-1:0]   tags,
  output logic                                busy,
  output logic [DATA_W-1:0]                   val,
  output logic [ROB_POS_W-1:0]                rob_pos
);
  // Stored entry, overridden by a retiring write; a newer owner keeps it busy.
  always_comb begin
    busy    = busys[pos];
    val     = vals[pos];
    rob_pos = tags[pos];
    if (hits_commit(rdy, commit, commit_rd, pos)) begin
      val = commit_val;
      if (tags[pos] == commit_rob_pos) busy = 1'b0;
    end
    if (pos == '0) begin
      busy = 1'b0;
      val  = '0;
    end
  end
endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with ROB-tag renaming and two read ports.
module reg_file_rename
  import reg_file_rename_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue,
  input  logic [REG_POS_W-1:0] issue_rd,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic                 commit,
  input  logic [REG_POS_W-1:0] commit_rd,
  input  logic [DATA_W-1:0]    commit_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos,
  input  logic [REG_POS_W-1:0] rs1_pos,
  output logic                 rs1_busy,
  output logic [DATA_W-1:0]    rs1_val,
  output logic [ROB_POS_W-1:0] rs1_rob_pos,
  input  logic [REG_POS_W-1:0] rs2_pos,
  output logic                 rs2_busy,
  output logic [DATA_W-1:0]    rs2_val,
  output logic [ROB_POS_W-1:0] rs2_rob_pos
);
  localparam int NUM_PORTS = 2;

  logic [REG_NUM-1:0][DATA_W-1:0]    val_q;
  logic [REG_NUM-1:0]                busy_q;
  logic [REG_NUM-1:0][ROB_POS_W-1:0] tag_q;

  // Commit first, then rollback/issue so the later rule wins on the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q  <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else if (rdy) begin
      if (commit && commit_rd != '0) begin
        val_q[commit_rd] <= commit_val;
        if (tag_q[commit_rd] == commit_rob_pos) busy_q[commit_rd] <= 1'b0;
      end
      if (rollback) begin
        busy_q <= '0;
      end else if (issue && issue_rd != '0) begin
        busy_q[issue_rd] <= 1'b1;
        tag_q[issue_rd]  <= issue_rob_pos;
      end
    end
  end

  logic [NUM_PORTS-1:0][REG_POS_W-1:0] rd_pos;
  logic [NUM_PORTS-1:0]                rd_busy;
  logic [NUM_PORTS-1:0][DATA_W-1:0]    rd_val;
  logic [NUM_PORTS-1:0][ROB_POS_W-1:0] rd_rob;

  assign rd_pos = {rs2_pos, rs1_pos};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    reg_file_read_port u_port (
      .rdy            (rdy),
      .commit         (commit),
      .commit_rd      (commit_rd),
      .commit_val     (commit_val),
      .commit_rob_pos (commit_rob_pos),
      .pos            (rd_pos[p]),
      .vals           (val_q),
      .busys          (busy_q),
      .tags           (tag_q),
      .busy           (rd_busy[p]),
      .val            (rd_val[p]),
      .rob_pos        (rd_rob[p])
    );
  end

  assign rs1_busy    = rd_busy[0];
  assign rs1_val     = rd_val[0];
  assign rs1_rob_pos = rd_rob[0];
  assign rs2_busy    = rd_busy[1];
  assign rs2_val     = rd_val[1];
  assign rs2_rob_pos = rd_rob[1];
endmodule

// File: tb/tb_reg_file_rename.sv
// Directed checks for the renaming register file.
module tb_reg_file_rename;
  logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, rollback = 1'b0;
  logic        issue = 1'b0, commit = 1'b0;
  logic [4:0]  issue_rd = '0, commit_rd = '0, rs1_pos = '0, rs2_pos = '0;
  logic [3:0]  issue_rob_pos = '0, commit_rob_pos = '0;
  logic [31:0] commit_val = '0;
  logic        rs1_busy, rs2_busy;
  logic [31:0] rs1_val, rs2_val;
  logic [3:0]  rs1_rob_pos, rs2_rob_pos;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  reg_file_rename dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
    .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_pos(commit_rob_pos),
    .rs1_pos(rs1_pos), .rs1_busy(rs1_busy), .rs1_val(rs1_val), .rs1_rob_pos(rs1_rob_pos),
    .rs2_pos(rs2_pos), .rs2_busy(rs2_busy), .rs2_val(rs2_val), .rs2_rob_pos(rs2_rob_pos)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [3:0] rob);
    issue = 1'b1; issue_rd = rd; issue_rob_pos = rob;
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [3:0] rob, input logic [31:0] v);
    commit = 1'b1; commit_rd = rd; commit_rob_pos = rob; commit_val = v;
  endtask

  task automatic idle();
    issue = 1'b0; commit = 1'b0; rollback = 1'b0; rdy = 1'b1;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    rs1_pos = 5'd5;
    #1;
    chk("rst_busy", rs1_busy, 0);
    chk("rst_val",  rs1_val,  0);
    chk("rst_rob",  rs1_rob_pos, 0);

    // 1. write x5, then async reset mid-cycle
    do_commit(5'd5, 4'd0, 32'h1234);
    tick(); idle();
    chk("x5_written", rs1_val, 32'h1234);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_val",  rs1_val, 0);
    chk("async_rst_busy", rs1_busy, 0);
    #1 rst_n = 1'b1;

    // 2. issue x3 rob 7, then commit it
    rs1_pos = 5'd3;
    do_issue(5'd3, 4'd7);
    #1;
    chk("own_rd_not_seen", rs1_busy, 0);
    tick(); idle();
    chk("x3_busy", rs1_busy, 1);
    chk("x3_rob",  rs1_rob_pos, 7);
    do_commit(5'd3, 4'd7, 32'hDEAD);
    #1;
    chk("byp_busy", rs1_busy, 0);
    chk("byp_val",  rs1_val, 32'hDEAD);
    tick(); idle();
    chk("x3_ret_busy", rs1_busy, 0);
    chk("x3_ret_val",  rs1_val, 32'hDEAD);

    // 3. rename chain: older commit leaves newer owner busy
    do_issue(5'd3, 4'd7); tick();
    do_issue(5'd3, 4'd9); tick(); idle();
    do_commit(5'd3, 4'd7, 32'h11);
    #1;
    chk("chain_byp_busy", rs1_busy, 1);
    chk("chain_byp_val",  rs1_val, 32'h11);
    tick(); idle();
    chk("chain_busy", rs1_busy, 1);
    chk("chain_rob",  rs1_rob_pos, 9);
    chk("chain_val",  rs1_val, 32'h11);

    // 4. same-cycle commit and issue to x4
    rs2_pos = 5'd4;
    do_issue(5'd4, 4'd2); tick(); idle();
    do_commit(5'd4, 4'd2, 32'hABCD);
    do_issue(5'd4, 4'd5);
    #1;
    chk("x4_byp_busy", rs2_busy, 0);
    chk("x4_byp_val",  rs2_val, 32'hABCD);
    tick(); idle();
    chk("x4_busy", rs2_busy, 1);
    chk("x4_rob",  rs2_rob_pos, 5);
    chk("x4_val",  rs2_val, 32'hABCD);

    // 5. x0 is never written and never busy
    rs1_pos = 5'd0;
    do_issue(5'd0, 4'd3); tick(); idle();
    chk("x0_busy_issue", rs1_busy, 0);
    do_commit(5'd0, 4'd3, 32'hFFFF_FFFF);
    #1;
    chk("x0_byp_val", rs1_val, 0);
    tick(); idle();
    chk("x0_val",  rs1_val, 0);
    chk("x0_busy", rs1_busy, 0);

    // 6. rollback held off by rdy=0, then applied
    do_issue(5'd1, 4'd1); tick();
    do_issue(5'd2, 4'd2); tick(); idle();
    rs1_pos = 5'd1; rs2_pos = 5'd2;
    rdy = 1'b0; rollback = 1'b1;
    do_commit(5'd1, 4'd1, 32'h42);
    do_issue(5'd6, 4'd3);
    #1;
    chk("hold_byp_off_busy", rs1_busy, 1);
    chk("hold_byp_off_val",  rs1_val, 0);
    tick();
    chk("hold_x1_busy", rs1_busy, 1);
    chk("hold_x2_busy", rs2_busy, 1);
    rs2_pos = 5'd6;
    #1;
    chk("hold_x6_busy", rs2_busy, 0);
    rdy = 1'b1;
    tick(); idle();
    chk("rb_x1_busy", rs1_busy, 0);
    chk("rb_x1_val",  rs1_val, 32'h42);
    chk("rb_x6_busy", rs2_busy, 0);
    rs1_pos = 5'd2; rs2_pos = 5'd4;
    #1;
    chk("rb_x2_busy", rs1_busy, 0);
    chk("rb_x4_busy", rs2_busy, 0);
    chk("rb_x4_val",  rs2_val, 32'hABCD);
    rs1_pos = 5'd3;
    #1;
    chk("rb_x3_busy", rs1_busy, 0);
    chk("rb_x3_val",  rs1_val, 32'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
